// File: rtl/key_event_queue.sv
// key_event_queue: edge-detects debounced key levels into key-code events
// and queues them in a show-ahead FIFO. Define KEY_RELEASE_EN for release events.
module key_event_queue #(
  parameter int WIDTH  = 18,
  parameter int CODE_W = 5,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       key_in,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [CODE_W-1:0]      evt_code,
  output logic                   evt_release,
  output logic [$clog2(DEPTH):0] evt_count,
  output logic                   overflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
`ifdef KEY_RELEASE_EN
  localparam int WORD_W = CODE_W + 1;
`else
  localparam int WORD_W = CODE_W;
`endif

  logic [WIDTH-1:0]  key_q, pend_p, rise, cand_p, sel_p, pend_p_nxt;
  logic              primed, have_p, room, push, pop, lost;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] push_word, head;

  function automatic logic [CODE_W-1:0] enc(input logic [WIDTH-1:0] oh);
    logic [CODE_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < WIDTH; i++)
      if (oh[i]) c = c | CODE_W'(i);
    return c;
  endfunction

  assign rise   = primed ? (key_in & ~key_q) : '0;
  assign cand_p = pend_p | rise;
  // Isolate lowest set bit: lowest-index candidate wins.
  assign sel_p  = cand_p & (~cand_p + 1'b1);
  assign have_p = |cand_p;
  assign room   = evt_count < FULL;
  assign evt_valid = evt_count != '0;
  assign pop    = evt_valid && evt_ready;
  assign head   = mem[rd_ptr];
  assign evt_code = evt_valid ? head[CODE_W-1:0] : '0;

`ifdef KEY_RELEASE_EN
  logic [WIDTH-1:0] pend_r, fall, cand_r, sel_r, pend_r_nxt;
  logic             have_r;

  assign fall   = primed ? (~key_in & key_q) : '0;
  assign cand_r = pend_r | fall;
  assign sel_r  = cand_r & (~cand_r + 1'b1);
  assign have_r = |cand_r;

  always_comb begin
    push       = room && (have_p || have_r);
    push_word  = have_p ? {1'b0, enc(sel_p)} : {1'b1, enc(sel_r)};
    pend_p_nxt = cand_p & ~((push && have_p) ? sel_p : '0);
    pend_r_nxt = cand_r & ~((push && !have_p) ? sel_r : '0);
    lost       = (|(rise & pend_p)) || (|(fall & pend_r));
  end

  assign evt_release = evt_valid & head[CODE_W];

  always_ff @(posedge clk) begin
    if (rst) pend_r <= '0;
    else     pend_r <= pend_r_nxt;
  end
`else
  always_comb begin
    push       = room && have_p;
    push_word  = enc(sel_p);
    pend_p_nxt = cand_p & ~(push ? sel_p : '0);
    lost       = |(rise & pend_p);
  end

  assign evt_release = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q     <= '0;
      primed    <= 1'b0;
      pend_p    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      key_q  <= key_in;
      primed <= 1'b1;
      pend_p <= pend_p_nxt;
      if (lost) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   evt_count <= evt_count + 1'b1;
        2'b01:   evt_count <= evt_count - 1'b1;
        default: evt_count <= evt_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= push_word;
  end
endmodule

// File: doc/key_event_queue.md
# key_event_queue

Converts the 18 debounced key/switch levels from the chattering-removal stage into a stream of discrete key events. Rising edges, and optionally falling edges, become 5-bit key codes that are serialized through a small show-ahead FIFO. Consumers read the FIFO with a valid/ready handshake; the crypto input controller uses this block to accept one key per event instead of polling levels.

## Interface

Parameters:
- WIDTH, 18, number of key lines; must be ≤ 2^CODE_W
- CODE_W, 5, width of the key code
- DEPTH, 8, FIFO entries; power of two, ≥ 2

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- key_in  input  WIDTH  debounced key levels, already synchronous to clk
- evt_valid  output  1  FIFO head holds an event
- evt_ready  input  1  consumer accepts head this cycle
- evt_code  output  CODE_W  index of the key in the head event
- evt_release  output  1  head event is a release (constant 0 unless KEY_RELEASE_EN)
- evt_count  output  $clog2(DEPTH)+1  FIFO occupancy
- overflow  output  1  sticky: an event was lost

## Operation

- key_q samples key_in every cycle. primed is 0 after reset; its first cycle loads key_q only and detects no edges, so keys held through reset produce no event. primed is 1 thereafter.
- rise = key_in & ~key_q; fall = ~key_in & key_q. Both are forced to 0 while primed=0.
- pend_p (and pend_r with KEY_RELEASE_EN) are WIDTH-bit masks of edges not yet queued.
- Candidate set = pend_p | rise. Release candidates = pend_r | fall.
- Selection: lowest-index press candidate first. If there are no press candidates, the lowest-index release candidate. At most one event is pushed per cycle.
- Push occurs when a candidate exists and evt_count < DEPTH, using occupancy registered at the start of the cycle. A same-cycle pop does not free a slot for that cycle's push.
- The pushed bit is cleared from its mask. All other candidates are retained in the masks.
- Overflow sets when a rise arrives on a bit already set in pend_p, or a fall on a bit already set in pend_r. The new edge merges and the event is lost. overflow is cleared only by rst.
- FIFO is show-ahead. evt_valid = (evt_count != 0). evt_code/evt_release come from mem[rd_ptr]. A pop occurs when evt_valid && evt_ready.
- Pointers are $clog2(DEPTH) bits and wrap naturally. evt_count increments on push-only, decrements on pop-only, and is unchanged on push+pop.
- evt_ready while empty has no effect.

## Timing

- Reset values: evt_valid=0, evt_code=0, evt_release=0, evt_count=0, overflow=0, pend_p=pend_r=0, key_q=0, primed=0, pointers=0. FIFO memory contents are don't-care.
- Latency: a key_in rise present before edge k (with FIFO empty, no other candidates, primed=1) gives evt_valid=1 with that code after edge k.
- Simultaneous rises on N keys: the events appear on N consecutive cycles in ascending index order, given FIFO space.
- FIFO full: candidates wait in the masks and are pushed on the first cycle after a pop lowers the registered count.
- rst asserted mid-operation: at the next edge all state returns to reset values, queued and pending events are discarded, and re-priming follows.

## Configuration

- KEY_RELEASE_EN defined:
  - pend_r and falling-edge detection are compiled in.
  - Release events are queued with evt_release=1.
  - The FIFO word is CODE_W+1 bits.
- KEY_RELEASE_EN undefined:
  - Falls are ignored.
  - pend_r does not exist.
  - evt_release is tied to 0.
  - The FIFO word is CODE_W bits.

## Test plan

- Reset with key_in=18'h00001 held, then release rst, evt_ready=1 → no event ever appears. Next, drop key 0 and raise it again → exactly one event, code 0.
- evt_ready=1, key_in 0 → 18'h00024 in one cycle → code 2 on the first valid cycle, code 5 on the next, then evt_valid=0.
- evt_ready=0, rise keys 0..9 one at a time → evt_count saturates at 8 and codes 8 and 9 stay pending. Then raise evt_ready → codes 0..9 are read in order and overflow=0.
- With key 3 pending and FIFO full, toggle key 3 low then high → overflow=1 and stays 1. Assert rst → overflow=0, evt_count=0.
- With KEY_RELEASE_EN: press then release key 17 with evt_ready=1 → events (17, release 0) then (17, release 1). Without the macro → only (17, release 0).
- Wrap-around: push and pop 20 events with evt_ready toggling every cycle → codes match issue order and evt_count never exceeds DEPTH.
